// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
// AND/OR/ADD/SUB/SLT and undefined codes complete in one cycle.
// MUL is a shift-add loop that runs for WIDTH cycles.
// Define ALU_DIV_EN to build the restoring DIV/REM unit and the div0_o flag.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             div0_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_REM = 4'b1010;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg, b_reg, acc;
    logic             accept, is_mul, last_iter;
    logic [WIDTH-1:0] sum, diff, sc_result, mul_acc;
    logic             sc_ovf;

    assign accept    = valid_i && ready_o;
    assign is_mul    = (ctrl_i == OP_MUL);
    assign last_iter = (cnt == LAST_CNT);
    assign sum       = src1_i + src2_i;
    assign diff      = src1_i - src2_i;
    assign mul_acc   = acc + (b_reg[0] ? a_reg : '0);

`ifdef ALU_DIV_EN
    // a_reg holds the quotient, b_reg the divisor and acc the partial remainder
    logic             is_div, op_rem;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next, quo_next, div_result, div0_result;

    assign is_div = (ctrl_i == OP_DIV) || (ctrl_i == OP_REM);

    // One restoring division step; the shifted remainder needs one extra bit
    always_comb begin
        rem_shift   = {acc, a_reg[WIDTH-1]};
        rem_ge      = (rem_shift >= {1'b0, b_reg});
        rem_next    = rem_ge ? (rem_shift[WIDTH-1:0] - b_reg) : rem_shift[WIDTH-1:0];
        quo_next    = {a_reg[WIDTH-2:0], rem_ge};
        div_result  = op_rem ? rem_next : quo_next;
        div0_result = op_rem ? a_reg : '1;
    end
`else
    assign div0_o = 1'b0;
`endif

    // Single-cycle result and signed overflow, evaluated straight from the inputs
    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (ctrl_i)
            OP_AND: sc_result = src1_i & src2_i;
            OP_OR:  sc_result = src1_i | src2_i;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: sc_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: multi-cycle ops leave IDLE, finish on their last iteration
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul) state_next = MUL;
`ifdef ALU_DIV_EN
                else if (accept && is_div) state_next = DIV;
`endif
            end
            MUL: if (last_iter) state_next = IDLE;
`ifdef ALU_DIV_EN
            DIV: if (last_iter || (b_reg == '0)) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ready whenever idle, including the cycle valid_o is high
    always_comb begin
        ready_o = (state == IDLE);
    end

    // Datapath: operand latching, iteration registers and registered results
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            ovf_o    <= 1'b0;
`ifdef ALU_DIV_EN
            op_rem   <= 1'b0;
            div0_o   <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            a_reg <= src1_i;
                            b_reg <= src2_i;
                            acc   <= '0;
                            cnt   <= '0;
                        end
`ifdef ALU_DIV_EN
                        else if (is_div) begin
                            a_reg  <= src1_i;
                            b_reg  <= src2_i;
                            acc    <= '0;
                            cnt    <= '0;
                            op_rem <= (ctrl_i == OP_REM);
                        end
`endif
                        else begin
                            result_o <= sc_result;
                            zero_o   <= (sc_result == '0);
                            ovf_o    <= sc_ovf;
                            valid_o  <= 1'b1;
`ifdef ALU_DIV_EN
                            div0_o   <= 1'b0;
`endif
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_acc;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        result_o <= mul_acc;
                        zero_o   <= (mul_acc == '0);
                        ovf_o    <= 1'b0;
                        valid_o  <= 1'b1;
`ifdef ALU_DIV_EN
                        div0_o   <= 1'b0;
`endif
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    if (b_reg == '0) begin
                        result_o <= div0_result;
                        zero_o   <= (div0_result == '0);
                        ovf_o    <= 1'b0;
                        div0_o   <= 1'b1;
                        valid_o  <= 1'b1;
                    end else begin
                        acc   <= rem_next;
                        a_reg <= quo_next;
                        cnt   <= cnt + 1'b1;
                        if (last_iter) begin
                            result_o <= div_result;
                            zero_o   <= (div_result == '0);
                            ovf_o    <= 1'b0;
                            div0_o   <= 1'b0;
                            valid_o  <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
